dmem_initiator: RTL

- CPU-side master for the data-memory port of the word-addressed memory model.
- Converts a single-outstanding valid/ready request from the MEM stage into the memory's d_readM/d_writeM/d_address/d_data/d_ready strobe protocol.
- Owns the CPU end of the bidirectional d_data bus and returns read data, or write completion, as a one-cycle response pulse.
- Includes a watchdog that flags a hung memory.

---
 rtl/dmem_initiator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_initiator.sv
// CPU-side master for the data-memory port. It turns a single-outstanding
// valid/ready request into the d_readM/d_writeM/d_ready strobe handshake.
module dmem_initiator #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    input  logic                 d_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t                state;
    logic                  write_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic [CW-1:0]         cnt;
    logic                  expire;

    // This edge closes the TIMEOUT_CYCLES-th busy cycle since ISSUE entry.
    assign expire = (cnt >= CW'(TIMEOUT_CYCLES - 1));

    // d_writeM is high exactly in ISSUE for a write, so it doubles as the bus enable.
    assign d_data = d_writeM ? wdata_q : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            d_readM    <= 1'b0;
            d_writeM   <= 1'b0;
            d_address  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        d_address <= req_addr;
                        d_readM   <= ~req_write;
                        d_writeM  <= req_write;
                        cnt       <= '0;
                        resp_err  <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (expire) begin
                        d_readM    <= 1'b0;
                        d_writeM   <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (d_ready) begin
                        // Memory latches the request on this edge.
                        d_readM  <= 1'b0;
                        d_writeM <= 1'b0;
                        state    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    cnt <= cnt + 1'b1;
                    if (expire) begin
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (!d_ready) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    cnt <= cnt + 1'b1;
                    // A completion on the last allowed edge still beats the watchdog.
                    if (d_ready) begin
                        if (!write_q) resp_rdata <= d_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (expire) begin
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    d_readM   <= 1'b0;
                    d_writeM  <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
